// File: rtl/junction_phase_arbiter_pkg.sv
// Shared definitions for the junction phase arbiter.
// Holds lamp codes, phase and state encodings, default timing constants,
// the packed lamp bundle type and the lamp decode helper used by the top.
package junction_phase_arbiter_pkg;

  // Lamp codes, one-hot {R,Y,G}
  localparam logic [2:0] LAMP_RED = 3'b100;
  localparam logic [2:0] LAMP_YEL = 3'b010;
  localparam logic [2:0] LAMP_GRN = 3'b001;

  // Default timing, in clk cycles
  localparam int unsigned DEF_T_MIN_GREEN = 7;
  localparam int unsigned DEF_T_MAX_GREEN = 20;
  localparam int unsigned DEF_T_YELLOW    = 3;
  localparam int unsigned DEF_T_ALLRED    = 2;

  typedef enum logic [1:0] {
    ST_GREEN  = 2'd0,
    ST_YELLOW = 2'd1,
    ST_ALLRED = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    PH_MAIN = 2'd0,
    PH_TURN = 2'd1,
    PH_SIDE = 2'd2,
    PH_PED  = 2'd3
  } phase_e;

  typedef struct packed {
    logic [2:0] m1;
    logic [2:0] m2;
    logic [2:0] mt;
    logic [2:0] s;
    logic       walk;
    logic       ped_flash;
  } lamps_t;

  localparam lamps_t LAMPS_ALL_RED = {LAMP_RED, LAMP_RED, LAMP_RED, LAMP_RED, 1'b0, 1'b0};

  // Lamp pattern for a given state/phase; anything not GREEN/YELLOW is all red.
  function automatic lamps_t decode_lamps(input state_e st, input phase_e ph);
    lamps_t     l;
    logic [2:0] c;
    l = LAMPS_ALL_RED;
    c = (st == ST_GREEN) ? LAMP_GRN : LAMP_YEL;
    if ((st == ST_GREEN) || (st == ST_YELLOW)) begin
      case (ph)
        PH_MAIN: begin l.m1 = c; l.m2 = c; end
        PH_TURN: begin l.m1 = c; l.mt = c; end
        PH_SIDE: begin l.s = c; end
        PH_PED:  begin
          l.walk      = (st == ST_GREEN);
          l.ped_flash = (st == ST_YELLOW);
        end
        default: l = LAMPS_ALL_RED;
      endcase
    end else begin
      l = LAMPS_ALL_RED;
    end
    return l;
  endfunction

endpackage

// File: rtl/junction_phase_arbiter_rr_phase_pick.sv
// Round-robin next-phase picker.
// Ports:
//   pend  - pending requests, one bit per phase (MAIN, TURN, SIDE, PED)
//   phase - phase currently being served
//   nxt   - first pending phase after 'phase', cyclic mod 4; 'phase' if none
module rr_phase_pick
  import junction_phase_arbiter_pkg::*;
(
  input  logic [3:0] pend,
  input  phase_e     phase,
  output phase_e     nxt
);

  logic [1:0] idx_s;
  logic       found_s;

  // Scan phase+1, phase+2, phase+3 and keep the first pending one.
  always_comb begin
    nxt     = phase;
    found_s = 1'b0;
    idx_s   = 2'd0;
    for (int unsigned k = 1; k < 4; k++) begin
      idx_s = phase + 2'(k);
      if (!found_s && pend[idx_s]) begin
        nxt     = phase_e'(idx_s);
        found_s = 1'b1;
      end else begin
        found_s = found_s;
      end
    end
  end

endmodule

// File: rtl/junction_phase_arbiter.sv
// Four-phase junction arbiter: MAIN, TURN, SIDE and pedestrian (PED).
// Each phase runs GREEN -> YELLOW -> ALLRED; requests are latched in pend
// and served round-robin. MAIN rests in green when nothing is pending.
// Ports:
//   clk       - sole clock, one cycle per timing unit
//   rst       - asynchronous active-low reset
//   req[3:0]  - vehicle detectors: 0 MAIN, 1 TURN, 2 SIDE, 3 ignored
//   ped_btn   - pedestrian button, any-width pulse
//   light_*   - lamp codes {R,Y,G} for M1, M2, MT, S
//   walk      - walk lamp (PED green)
//   ped_flash - flashing don't-walk (PED yellow)
//   phase     - current phase
//   state     - current state (GREEN=0, YELLOW=1, ALLRED=2)
module junction_phase_arbiter
  import junction_phase_arbiter_pkg::*;
#(
  parameter int unsigned T_MIN_GREEN = DEF_T_MIN_GREEN,
  parameter int unsigned T_MAX_GREEN = DEF_T_MAX_GREEN,
  parameter int unsigned T_YELLOW    = DEF_T_YELLOW,
  parameter int unsigned T_ALLRED    = DEF_T_ALLRED
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  input  logic       ped_btn,
  output logic [2:0] light_M1,
  output logic [2:0] light_M2,
  output logic [2:0] light_MT,
  output logic [2:0] light_S,
  output logic       walk,
  output logic       ped_flash,
  output logic [1:0] phase,
  output logic [1:0] state
);

  // Last timer value of each interval (timer counts from 0 on state entry).
  localparam logic [7:0] MIN_LAST = 8'(T_MIN_GREEN - 1);
  localparam logic [7:0] MAX_LAST = 8'(T_MAX_GREEN - 1);
  localparam logic [7:0] YEL_LAST = 8'(T_YELLOW - 1);
  localparam logic [7:0] AR_LAST  = 8'(T_ALLRED - 1);

  state_e     state_q,     state_d;
  phase_e     phase_q,     phase_d;
  phase_e     nxt_phase_q, nxt_phase_d;
  logic [7:0] timer_q,     timer_d;
  logic [3:0] pend_q,      pend_d;
  lamps_t     lamps_q,     lamps_d;

  logic [3:0] others_s;
  logic [3:0] pend_set_s;
  logic [3:0] pend_clr_s;
  logic       enter_green_s;
  logic       go_s;
  phase_e     cand_s;
  phase_e     pick_s;

  // Requests from phases other than the one being served.
  assign others_s = pend_q & ~(4'b0001 << phase_q);

  rr_phase_pick u_pick (
    .pend  (others_s),
    .phase (phase_q),
    .nxt   (pick_s)
  );

  // Next-state, timer and pend bookkeeping.
  always_comb begin
    state_d       = state_q;
    phase_d       = phase_q;
    nxt_phase_d   = nxt_phase_q;
    timer_d       = (timer_q == 8'hFF) ? timer_q : (timer_q + 8'd1);
    go_s          = 1'b0;
    cand_s        = PH_MAIN;
    enter_green_s = (state_q == ST_ALLRED) && (timer_q >= AR_LAST);

    case (state_q)
      ST_GREEN: begin
        if (|others_s) begin
          cand_s = pick_s;
          if (phase_q == PH_PED) begin
            go_s = (timer_q >= MIN_LAST);
          end else begin
            // ">=" on the max-out also releases a green whose timer has
            // already saturated while resting with no competitor.
            go_s = ((timer_q >= MIN_LAST) && !req[phase_q]) || (timer_q >= MAX_LAST);
          end
        end else if (phase_q != PH_MAIN) begin
          cand_s = PH_MAIN;
          go_s   = (timer_q >= MIN_LAST);
        end else begin
          go_s = 1'b0;
        end
        if (go_s) begin
          state_d     = ST_YELLOW;
          timer_d     = 8'd0;
          nxt_phase_d = cand_s;
        end else begin
          state_d = ST_GREEN;
        end
      end
      ST_YELLOW: begin
        if (timer_q >= YEL_LAST) begin
          state_d = ST_ALLRED;
          timer_d = 8'd0;
        end else begin
          state_d = ST_YELLOW;
        end
      end
      ST_ALLRED: begin
        if (enter_green_s) begin
          state_d = ST_GREEN;
          timer_d = 8'd0;
          phase_d = nxt_phase_q;
        end else begin
          state_d = ST_ALLRED;
        end
      end
      default: begin
        state_d = ST_ALLRED;
        timer_d = 8'd0;
      end
    endcase

    // The served phase cannot re-request itself; entering green clears its
    // bit and the clear beats a set arriving in the same cycle.
    pend_set_s = {ped_btn, req[2:0]} &
                 ~((state_q == ST_GREEN) ? (4'b0001 << phase_q) : 4'b0000);
    pend_clr_s = enter_green_s ? (4'b0001 << nxt_phase_q) : 4'b0000;
    pend_d     = (pend_q | pend_set_s) & ~pend_clr_s;

    // Lamps are decoded from the next state so the registered lamps line up
    // with the registered state/phase.
    lamps_d = decode_lamps(state_d, phase_d);
  end

  // All state and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_ALLRED;
      phase_q     <= PH_MAIN;
      nxt_phase_q <= PH_MAIN;
      timer_q     <= 8'd0;
      pend_q      <= 4'b0000;
      lamps_q     <= LAMPS_ALL_RED;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      nxt_phase_q <= nxt_phase_d;
      timer_q     <= timer_d;
      pend_q      <= pend_d;
      lamps_q     <= lamps_d;
    end
  end

  assign light_M1  = lamps_q.m1;
  assign light_M2  = lamps_q.m2;
  assign light_MT  = lamps_q.mt;
  assign light_S   = lamps_q.s;
  assign walk      = lamps_q.walk;
  assign ped_flash = lamps_q.ped_flash;
  assign phase     = phase_q;
  assign state     = state_q;

endmodule

// File: tb/tb_junction_phase_arbiter.sv
// Directed bench for junction_phase_arbiter with default timing
// (min green 7, max green 20, yellow 3, all-red 2).
module tb_junction_phase_arbiter;

  localparam logic [1:0] S_G  = 2'd0;
  localparam logic [1:0] S_Y  = 2'd1;
  localparam logic [1:0] S_AR = 2'd2;
  localparam logic [1:0] P_M  = 2'd0;
  localparam logic [1:0] P_T  = 2'd1;
  localparam logic [1:0] P_S  = 2'd2;
  localparam logic [1:0] P_P  = 2'd3;
  localparam logic [13:0] ALL_RED = 14'b100_100_100_100_0_0;

  logic       clk;
  logic       rst;
  logic [3:0] req;
  logic       ped_btn;
  logic [2:0] light_M1, light_M2, light_MT, light_S;
  logic       walk, ped_flash;
  logic [1:0] phase, state;
  logic [13:0] outs;
  logic [2:0] req_hold;

  int checks;
  int errors;

  junction_phase_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .ped_btn   (ped_btn),
    .light_M1  (light_M1),
    .light_M2  (light_M2),
    .light_MT  (light_MT),
    .light_S   (light_S),
    .walk      (walk),
    .ped_flash (ped_flash),
    .phase     (phase),
    .state     (state)
  );

  assign outs = {light_M1, light_M2, light_MT, light_S, walk, ped_flash};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", tag, obs, exp);
    end
  endtask

  // Hand-written lamp table: {M1,M2,MT,S,walk,ped_flash}.
  function automatic logic [13:0] exp_out(input logic [1:0] st, input logic [1:0] ph);
    logic [2:0] c;
    c = (st == S_G) ? 3'b001 : 3'b010;
    if (st == S_AR) return ALL_RED;
    case (ph)
      P_M:     return {c, c, 3'b100, 3'b100, 1'b0, 1'b0};
      P_T:     return {c, 3'b100, c, 3'b100, 1'b0, 1'b0};
      P_S:     return {3'b100, 3'b100, 3'b100, c, 1'b0, 1'b0};
      default: return {3'b100, 3'b100, 3'b100, 3'b100, (st == S_G), (st == S_Y)};
    endcase
  endfunction

  // Measure how long (state, phase) holds from the current negedge, checking
  // lamps every cycle. 'pulse' drives {ped_btn, req[2:0]} for the first cycle.
  task automatic seg(input string tag, input logic [1:0] st, input logic [1:0] ph,
                     input int len, input int limit, input logic [3:0] pulse);
    int          n;
    logic [31:0] want;
    logic [31:0] seen;
    want    = {18'd0, exp_out(st, ph)};
    seen    = want;
    req     = {1'b0, req_hold | pulse[2:0]};
    ped_btn = pulse[3];
    n       = 0;
    while ((n < limit) && (state == st) && (phase == ph)) begin
      if ((outs !== want[13:0]) && (seen == want)) seen = {18'd0, outs};
      n++;
      @(negedge clk);
      req     = {1'b0, req_hold};
      ped_btn = 1'b0;
    end
    check_eq({tag, "_lamps"}, seen, want);
    check_eq({tag, "_len"}, n, len);
  endtask

  // Reset for two cycles, check reset values, release and ride out all-red.
  task automatic do_reset(input string tag);
    rst      = 1'b0;
    req      = 4'b0000;
    ped_btn  = 1'b0;
    req_hold = 3'b000;
    @(negedge clk);
    check_eq({tag, "_rst_state"}, state, S_AR);
    check_eq({tag, "_rst_phase"}, phase, P_M);
    check_eq({tag, "_rst_lamps"}, outs, ALL_RED);
    @(negedge clk);
    rst = 1'b1;
    seg({tag, "_rel_ar"}, S_AR, P_M, 2, 10, 4'b0000);
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    rst      = 1'b1;
    req      = 4'b0000;
    ped_btn  = 1'b0;
    req_hold = 3'b000;
    #2;

    // Idle: MAIN rests green.
    do_reset("idle");
    seg("idle_rest", S_G, P_M, 120, 120, 4'b0000);

    // SIDE request at MAIN timer 0.
    do_reset("side");
    seg("side_mg", S_G,  P_M, 7, 40, 4'b0100);
    seg("side_my", S_Y,  P_M, 3, 10, 4'b0000);
    seg("side_ma", S_AR, P_M, 2, 10, 4'b0000);
    seg("side_sg", S_G,  P_S, 7, 40, 4'b0000);
    seg("side_sy", S_Y,  P_S, 3, 10, 4'b0000);
    seg("side_sa", S_AR, P_S, 2, 10, 4'b0000);
    seg("side_back", S_G, P_M, 5, 5, 4'b0000);

    // TURN and SIDE together: TURN first, then SIDE, then MAIN.
    do_reset("rr");
    seg("rr_mg", S_G,  P_M, 7, 40, 4'b0110);
    seg("rr_my", S_Y,  P_M, 3, 10, 4'b0000);
    seg("rr_ma", S_AR, P_M, 2, 10, 4'b0000);
    seg("rr_tg", S_G,  P_T, 7, 40, 4'b0000);
    seg("rr_ty", S_Y,  P_T, 3, 10, 4'b0000);
    seg("rr_ta", S_AR, P_T, 2, 10, 4'b0000);
    seg("rr_sg", S_G,  P_S, 7, 40, 4'b0000);
    seg("rr_sy", S_Y,  P_S, 3, 10, 4'b0000);
    seg("rr_sa", S_AR, P_S, 2, 10, 4'b0000);
    seg("rr_back", S_G, P_M, 5, 5, 4'b0000);

    // MAIN demand held while SIDE waits: max-out at 20.
    do_reset("max");
    req_hold = 3'b001;
    seg("max_mg", S_G, P_M, 20, 60, 4'b0100);
    req_hold = 3'b000;
    seg("max_my", S_Y,  P_M, 3, 10, 4'b0000);
    seg("max_ma", S_AR, P_M, 2, 10, 4'b0000);
    seg("max_sg", S_G,  P_S, 7, 40, 4'b0000);
    seg("max_sy", S_Y,  P_S, 3, 10, 4'b0000);
    seg("max_sa", S_AR, P_S, 2, 10, 4'b0000);
    seg("max_back", S_G, P_M, 5, 5, 4'b0000);

    // Pedestrian cycle.
    do_reset("ped");
    seg("ped_mg", S_G,  P_M, 7, 40, 4'b1000);
    seg("ped_my", S_Y,  P_M, 3, 10, 4'b0000);
    seg("ped_ma", S_AR, P_M, 2, 10, 4'b0000);
    seg("ped_walk",  S_G,  P_P, 7, 40, 4'b0000);
    seg("ped_flash", S_Y,  P_P, 3, 10, 4'b0000);
    seg("ped_pa",    S_AR, P_P, 2, 10, 4'b0000);
    seg("ped_back",  S_G,  P_M, 5, 5, 4'b0000);

    // Reset in SIDE yellow with PED pending: no yellow finish, no PED after.
    do_reset("mid");
    seg("mid_mg", S_G,  P_M, 7, 40, 4'b0100);
    seg("mid_my", S_Y,  P_M, 3, 10, 4'b0000);
    seg("mid_ma", S_AR, P_M, 2, 10, 4'b0000);
    seg("mid_sg", S_G,  P_S, 7, 40, 4'b1000);
    check_eq("mid_in_yellow", {state, phase}, {S_Y, P_S});
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_eq("mid_rst_state", state, S_AR);
    check_eq("mid_rst_phase", phase, P_M);
    check_eq("mid_rst_lamps", outs, ALL_RED);
    @(negedge clk);
    rst = 1'b1;
    seg("mid_rel_ar", S_AR, P_M, 2, 10, 4'b0000);
    seg("mid_no_ped", S_G, P_M, 30, 30, 4'b0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/junction_phase_arbiter.md
JUNCTION_PHASE_ARBITER -- requirements
Module: junction_phase_arbiter

Interface
REQ-001 SHALL have parameter T_MIN_GREEN, default 7, minimum green/walk length in clk cycles (>=2).
REQ-002 SHALL have parameter T_MAX_GREEN, default 20, maximum green length while another phase waits (>T_MIN_GREEN, <=255).
REQ-003 SHALL have parameter T_YELLOW, default 3, yellow/flash-don't-walk length in cycles (>=1).
REQ-004 SHALL have parameter T_ALLRED, default 2, all-red clearance length in cycles (>=1).
REQ-005 SHALL have port clk  input  1  sole clock, one cycle per timing unit.
REQ-006 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-007 SHALL have port req  input  4  level vehicle detectors, index 0 MAIN, 1 TURN, 2 SIDE, 3 unused (ignored).
REQ-008 SHALL have port ped_btn  input  1  pedestrian button, any-width pulse.
REQ-009 SHALL have ports light_M1, light_M2, light_MT, light_S  output  3 each  lamp code {R,Y,G}: red 3'b100, yellow 3'b010, green 3'b001.
REQ-010 SHALL have ports walk, ped_flash  output  1 each  pedestrian walk and flashing don't-walk.
REQ-011 SHALL have ports phase  output  2  current phase, and state  output  2  current state (GREEN=0, YELLOW=1, ALLRED=2).

Function
REQ-012 Phases SHALL be MAIN=0 (M1,M2 green), TURN=1 (M1,MT green), SIDE=2 (S green), PED=3 (all vehicle red, walk=1).
REQ-013 State machine SHALL be GREEN -> YELLOW -> ALLRED -> GREEN, with an 8-bit timer cleared on every state entry and saturating at 255.
REQ-014 pend[2:0] SHALL latch req[2:0] high and pend[3] SHALL latch ped_btn high, except the bit of the phase currently in GREEN, which is not set.
REQ-015 On ALLRED->GREEN entry, pend of the entering phase SHALL clear, and clear SHALL win over a same-cycle set.
REQ-016 In GREEN with any other pend set, the FSM SHALL go to YELLOW when (timer>=T_MIN_GREEN-1 and req[phase]==0) or timer==T_MAX_GREEN-1; PED ignores req and leaves at timer==T_MIN_GREEN-1.
REQ-017 In GREEN with no pend set and phase!=MAIN, the FSM SHALL go to YELLOW at timer==T_MIN_GREEN-1 with next phase MAIN; MAIN with no pend SHALL rest in GREEN indefinitely.
REQ-018 Next phase SHALL be chosen at the GREEN->YELLOW edge, round-robin: first pend index after phase, cyclic mod 4, held in nxt_phase.
REQ-019 YELLOW SHALL last exactly T_YELLOW cycles and ALLRED exactly T_ALLRED cycles, then GREEN with phase=nxt_phase.
REQ-020 In GREEN, lamps of the active phase SHALL be green and all others red; in YELLOW those same lamps SHALL be yellow; in ALLRED all lamps SHALL be red.
REQ-021 walk SHALL be 1 only in PED/GREEN, ped_flash SHALL be 1 only in PED/YELLOW, and no vehicle lamp SHALL be non-red while walk or ped_flash is 1.
REQ-022 All outputs SHALL be registered (decoded from registered state, phase and timer), with no combinational path from inputs to outputs.

Reset
REQ-023 rst low SHALL immediately force state=ALLRED, phase=MAIN, nxt_phase=MAIN, timer=0, pend=0, all lamps 3'b100, walk=0, ped_flash=0.
REQ-024 After rst deasserts, the first GREEN (MAIN) SHALL begin T_ALLRED cycles later, and reset asserted mid-phase SHALL abandon that phase with no yellow.

Structure
REQ-025 A shared package SHALL hold the lamp codes, phase encodings, state encodings and default timing constants.
REQ-026 The round-robin next-phase picker SHALL be a sub-module, rr_phase_pick (inputs pend, phase; output nxt).

Verification
REQ-027 Scenario: release rst, req=0 -> all red 2 cycles, then light_M1=light_M2=3'b001 held for 100+ cycles.
REQ-028 Scenario: in MAIN green, 1-cycle req[2] at timer=0, req[0]=0 -> MAIN green 7, yellow 3, all-red 2, S green 7, then yellow 3, all-red 2, MAIN green.
REQ-029 Scenario: req[1] and req[2] pulsed same cycle from MAIN -> service order TURN then SIDE, then MAIN.
REQ-030 Scenario: MAIN with req[0] held high and req[2] pending -> MAIN green exactly 20 cycles (max-out) before yellow.
REQ-031 Scenario: ped_btn pulse during MAIN -> after all-red, walk=1 7 cycles with all lamps red, ped_flash=1 3 cycles, all-red 2, then MAIN.
REQ-032 Scenario: rst asserted mid-YELLOW of SIDE with pend[3] set -> lamps all red same cycle, pend=0, MAIN green 2 cycles after release, no PED phase.
